// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer:
// FSM states, branch opcodes, condition codes and CPSR flag positions.
package fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      COND,
      HOLD
   } state_t;

   localparam logic [6:0] BR_UNCOND = 7'b1100000;
   localparam logic [6:0] BR_COND   = 7'b1100001;

   localparam logic [3:0] CC_EQ = 4'b0001;
   localparam logic [3:0] CC_NE = 4'b0000;
   localparam logic [3:0] CC_CS = 4'b0010;
   localparam logic [3:0] CC_CC = 4'b0011;
   localparam logic [3:0] CC_MI = 4'b0100;
   localparam logic [3:0] CC_PL = 4'b0101;
   localparam logic [3:0] CC_VS = 4'b0110;
   localparam logic [3:0] CC_VC = 4'b0111;
   localparam logic [3:0] CC_HI = 4'b1000;
   localparam logic [3:0] CC_LS = 4'b1001;
   localparam logic [3:0] CC_GE = 4'b1010;
   localparam logic [3:0] CC_LT = 4'b1011;
   localparam logic [3:0] CC_GT = 4'b1100;
   localparam logic [3:0] CC_LE = 4'b1101;
   localparam logic [3:0] CC_AL = 4'b1110;
   localparam logic [3:0] CC_NV = 4'b1111;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_V = 0;

   // PC-relative target, wrapping modulo 2^32.
   function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                 input logic [15:0] imm);
      return pc + {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory, flag and delivery signals of the fetch sequencer; master is the
// sequencer side, slave the surrounding memory/pipeline side.
interface fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [3:0]  flags;
   logic        flags_valid;
   logic        stall;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_ready, imem_rdata, flags, flags_valid, stall
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_ready, imem_rdata, flags, flags_valid, stall
   );
endinterface

// File: rtl/fetch_sequencer_cond_eval.sv
// Combinational branch-condition evaluator over the N/C/Z/V flags.
module cond_eval
   import fetch_sequencer_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       taken
);

   logic n, c, z, v;

   always_comb begin
      n     = flags[FLAG_N];
      c     = flags[FLAG_C];
      z     = flags[FLAG_Z];
      v     = flags[FLAG_V];
      taken = 1'b0;
      case (cond)
         CC_EQ: taken = z;
         CC_NE: taken = !z;
         CC_CS: taken = c;
         CC_CC: taken = !c;
         CC_MI: taken = n;
         CC_PL: taken = !n;
         CC_VS: taken = v;
         CC_VC: taken = !v;
         CC_HI: taken = c && !z;
         CC_LS: taken = !(c && !z);
         CC_GE: taken = (n == v);
         CC_LT: taken = (n != v);
         CC_GT: taken = !z && (n == v);
         CC_LE: taken = !(!z && (n == v));
         CC_AL: taken = 1'b1;
         CC_NV: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with same-cycle unconditional
// branches and flag-gated conditional branches.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   fetch_sequencer_if.master bus
);

   state_t      state, state_next;
   logic [31:0] fetch_pc;
   logic [31:0] instr_q;
   logic [31:0] instr_pc_q;
   logic        instr_valid_q;
   logic        req;
   logic        fire;
   logic        blocked;
   logic        taken;
   logic [6:0]  rd_op;

   assign rd_op   = bus.imem_rdata[31:25];
   assign blocked = instr_valid_q && bus.stall;
   assign fire    = req && bus.imem_ready;

   cond_eval u_cond_eval (
      .cond  (instr_q[28:25]),
      .flags (bus.flags),
      .taken (taken)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // A held instruction withdraws any request in flight; it is reissued from HOLD.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: state_next = REQ;
         REQ, WAIT: begin
            if (blocked)              state_next = HOLD;
            else if (bus.imem_ready)  state_next = (rd_op == BR_COND) ? COND : REQ;
            else                      state_next = WAIT;
         end
         COND: if (bus.flags_valid) state_next = REQ;
         HOLD: if (!bus.stall)      state_next = REQ;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req             = ((state == REQ) || (state == WAIT)) && !blocked;
      bus.imem_req    = req;
      bus.imem_addr   = fetch_pc;
      bus.instr       = instr_q;
      bus.instr_pc    = instr_pc_q;
      bus.instr_valid = instr_valid_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc      <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else if (fire) begin
         instr_q       <= bus.imem_rdata;
         instr_pc_q    <= fetch_pc;
         instr_valid_q <= 1'b1;
         fetch_pc      <= (rd_op == BR_UNCOND) ? branch_target(fetch_pc, bus.imem_rdata[15:0])
                                               : fetch_pc + 32'd4;
      end else begin
         if (instr_valid_q && !bus.stall) instr_valid_q <= 1'b0;
         if ((state == COND) && bus.flags_valid)
            fetch_pc <= taken ? branch_target(instr_pc_q, instr_q[15:0])
                              : instr_pc_q + 32'd4;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer and its cond_eval sub-module.
module tb_fetch_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   fetch_sequencer_if bus ();

   fetch_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [3:0] ce_cond;
   logic [3:0] ce_flags;
   logic       ce_taken;

   cond_eval u_ce (
      .cond  (ce_cond),
      .flags (ce_flags),
      .taken (ce_taken)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.imem_ready  = 1'b0;
      bus.imem_rdata  = '0;
      bus.flags       = '0;
      bus.flags_valid = 1'b0;
      bus.stall       = 1'b0;
   endtask

   // Leaves the bench in the IDLE cycle just after reset release.
   task automatic do_reset();
      drive_idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] w);
      bus.imem_ready = 1'b1;
      bus.imem_rdata = w;
      step();
      bus.imem_ready = 1'b0;
   endtask

   function automatic logic ref_taken(input logic [3:0] c, input logic [3:0] f);
      logic n, cf, z, v;
      n = f[3]; cf = f[2]; z = f[1]; v = f[0];
      case (c)
         4'd0:  return !z;
         4'd1:  return z;
         4'd2:  return cf;
         4'd3:  return !cf;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cf & !z;
         4'd9:  return !(cf & !z);
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z & (n == v);
         4'd13: return !(!z & (n == v));
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic test_reset();
      drive_idle();
      reset = 1'b1;
      bus.imem_ready = 1'b1;
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus.imem_addr); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.instr_valid); end
      checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", bus.instr); end
      checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", bus.instr_pc); end
      step();
      reset = 1'b0;
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", bus.imem_req); end
      step();
      #1;
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp 0", bus.imem_addr); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL idle_ignored_ready got %b exp 0", bus.instr_valid); end
   endtask

   task automatic test_sequential();
      do_reset();
      step();
      for (int i = 0; i < 4; i++) begin
         bus.imem_ready = 1'b1;
         bus.imem_rdata = 32'h0000_1000 + 32'(i);
         #1;
         checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d] got %b exp 1", i, bus.imem_req); end
         checks++; if (bus.imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, bus.imem_addr, 32'(4 * i)); end
         if (i > 0) begin
            checks++; if (bus.instr_pc !== 32'(4 * (i - 1))) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, bus.instr_pc, 32'(4 * (i - 1))); end
            checks++; if (bus.instr !== 32'h0000_1000 + 32'(i - 1)) begin errors++; $display("FAIL seq_instr[%0d] got %h", i, bus.instr); end
            checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b exp 1", i, bus.instr_valid); end
         end
         step();
      end
      checks++; if (bus.instr_pc !== 32'hC) begin errors++; $display("FAIL seq_last_pc got %h exp 0000000c", bus.instr_pc); end
      checks++; if (bus.instr !== 32'h0000_1003) begin errors++; $display("FAIL seq_last_instr got %h exp 00001003", bus.instr); end
   endtask

   task automatic test_uncond();
      do_reset();
      step();
      for (int i = 0; i < 4; i++) fetch(32'h0000_2000 + 32'(i));
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'hC000_FFF0;
      #1;
      checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL br_src_addr got %h exp 00000010", bus.imem_addr); end
      step();
      bus.imem_ready = 1'b0;
      #1;
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL br_tgt_addr got %h exp 0", bus.imem_addr); end
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL br_tgt_req got %b exp 1", bus.imem_req); end
      checks++; if (bus.instr !== 32'hC000_FFF0) begin errors++; $display("FAIL br_instr got %h exp c000fff0", bus.instr); end
      checks++; if (bus.instr_pc !== 32'h10) begin errors++; $display("FAIL br_pc got %h exp 00000010", bus.instr_pc); end
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL br_valid got %b exp 1", bus.instr_valid); end
   endtask

   task automatic test_wrap();
      do_reset();
      step();
      fetch(32'hC000_FFFC);
      #1;
      checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_neg got %h exp fffffffc", bus.imem_addr); end
      fetch(32'h0000_3000);
      #1;
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_inc got %h exp 0", bus.imem_addr); end
      checks++; if (bus.instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", bus.instr_pc); end
   endtask

   task automatic test_cond();
      for (int t = 0; t < 2; t++) begin
         do_reset();
         step();
         fetch(32'hC000_0040);
         bus.imem_ready = 1'b1;
         bus.imem_rdata = 32'hC200_0020;
         #1;
         checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL beq_src[%0d] got %h exp 00000040", t, bus.imem_addr); end
         step();
         bus.imem_rdata = 32'hDEAD_0000;
         for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL beq_wait_req[%0d,%0d] got %b exp 0", t, k, bus.imem_req); end
            checks++; if (bus.instr !== 32'hC200_0020) begin errors++; $display("FAIL beq_instr[%0d,%0d] got %h exp c2000020", t, k, bus.instr); end
            checks++; if (bus.instr_valid !== (k == 0)) begin errors++; $display("FAIL beq_valid[%0d,%0d] got %b exp %b", t, k, bus.instr_valid, k == 0); end
            step();
         end
         bus.flags_valid = 1'b1;
         bus.flags = (t == 0) ? 4'b0010 : 4'b0000;
         #1;
         checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL beq_eval_req[%0d] got %b exp 0", t, bus.imem_req); end
         step();
         bus.flags_valid = 1'b0;
         bus.imem_ready = 1'b0;
         #1;
         checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL beq_resume_req[%0d] got %b exp 1", t, bus.imem_req); end
         checks++; if (bus.imem_addr !== ((t == 0) ? 32'h60 : 32'h44)) begin errors++; $display("FAIL beq_target[%0d] got %h exp %h", t, bus.imem_addr, (t == 0) ? 32'h60 : 32'h44); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      step();
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'h1111_1111;
      step();
      bus.stall = 1'b1;
      bus.imem_rdata = 32'h2222_2222;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b exp 0", k, bus.imem_req); end
         checks++; if (bus.instr !== 32'h1111_1111) begin errors++; $display("FAIL stall_instr[%0d] got %h exp 11111111", k, bus.instr); end
         checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", k, bus.instr_valid); end
         checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 0", k, bus.instr_pc); end
         step();
      end
      bus.stall = 1'b0;
      bus.imem_ready = 1'b0;
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL hold_exit_req got %b exp 0", bus.imem_req); end
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL hold_exit_valid got %b exp 1", bus.instr_valid); end
      step();
      #1;
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL resume_req got %b exp 1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL resume_addr got %h exp 00000004", bus.imem_addr); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL resume_valid got %b exp 0", bus.instr_valid); end
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'h3333_3333;
      step();
      bus.imem_ready = 1'b0;
      #1;
      checks++; if (bus.instr !== 32'h3333_3333) begin errors++; $display("FAIL resume_instr got %h exp 33333333", bus.instr); end
      checks++; if (bus.instr_pc !== 32'h4) begin errors++; $display("FAIL resume_pc got %h exp 00000004", bus.instr_pc); end
   endtask

   task automatic test_wait_reset();
      do_reset();
      step();
      fetch(32'h4444_4444);
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d] got %b exp 1", k, bus.imem_req); end
         checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL wait_addr[%0d] got %h exp 00000004", k, bus.imem_addr); end
         step();
      end
      reset = 1'b1;
      bus.imem_ready = 1'b1;
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL wrst_req got %b exp 0", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrst_addr got %h exp 0", bus.imem_addr); end
      checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL wrst_instr got %h exp 0", bus.instr); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL wrst_valid got %b exp 0", bus.instr_valid); end
      step();
      reset = 1'b0;
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL wrst_idle_req got %b exp 0", bus.imem_req); end
      step();
      #1;
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL late_ready got %b exp 0", bus.instr_valid); end
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL restart_req got %b exp 1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL restart_addr got %h exp 0", bus.imem_addr); end
      bus.imem_ready = 1'b0;
   endtask

   task automatic test_cond_table();
      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            ce_cond  = 4'(c);
            ce_flags = 4'(f);
            #1;
            checks++;
            if (ce_taken !== ref_taken(4'(c), 4'(f))) begin
               errors++;
               $display("FAIL cond[%0d] flags %b got %b exp %b", c, 4'(f), ce_taken, ref_taken(4'(c), 4'(f)));
            end
         end
      end
   endtask

   initial begin
      drive_idle();
      ce_cond  = '0;
      ce_flags = '0;
      test_reset();
      test_sequential();
      test_uncond();
      test_wrap();
      test_cond();
      test_stall();
      test_wait_reset();
      test_cond_table();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-004 SHALL have port: imem_addr  output  32  word address of the current fetch.
REQ-005 SHALL have port: imem_ready  input  1  memory has returned imem_rdata this cycle.
REQ-006 SHALL have port: imem_rdata  input  32  fetched instruction word.
REQ-007 SHALL have port: flags  input  4  CPSR flags, [3]=N [2]=C [1]=Z [0]=V.
REQ-008 SHALL have port: flags_valid  input  1  flags reflect all older instructions.
REQ-009 SHALL have port: stall  input  1  downstream cannot accept instr this cycle.
REQ-010 SHALL have port: instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-011 SHALL have port: instr  output  32  delivered instruction.
REQ-012 SHALL have port: instr_pc  output  32  address of instr.

Function
REQ-013 SHALL implement states IDLE, REQ, WAIT, COND, HOLD.
REQ-014 IDLE: one cycle after reset release, then REQ with fetch_pc=0.
REQ-015 REQ/WAIT: imem_req=1, imem_addr=fetch_pc, both stable until imem_ready=1; REQ->WAIT if imem_ready=0.
REQ-016 On imem_ready=1: capture rdata into instr, instr_pc<=fetch_pc, instr_valid<=1 next cycle.
REQ-017 Delivery: instr_valid&!stall retires instr; instr_valid&stall -> state HOLD, instr/instr_pc/instr_valid unchanged, imem_req=0.
REQ-018 Next address, non-branch or cond 1111: fetch_pc+4.
REQ-019 Unconditional branch (instr[31:25]=1100000): next = instr_pc + sign-extend(instr[15:0]), decided same cycle as capture, no extra cycle.
REQ-020 Conditional branch (instr[31:25]=1100001): enter COND, imem_req=0 until flags_valid=1; evaluate cond=instr[28:25] in that cycle, next REQ.
REQ-021 Conditions: 0001 Z; 0000 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !(C&!Z); 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 !(!Z&(N==V)); 1110 always; 1111 never (nop).
REQ-022 Taken: next = instr_pc + sext(imm16); not taken: instr_pc+4.
REQ-023 Address arithmetic SHALL be 32-bit modulo (0xFFFFFFFC+4=0, 0x0+sext(0xFFFC)=0xFFFFFFFC).
REQ-024 Branch instructions SHALL still be delivered on instr with instr_valid=1.
REQ-025 Stall during COND SHALL not block evaluation; new fetch waits until stall=0.
REQ-026 Only one outstanding fetch; no request while instr_valid&stall.

Reset
REQ-027 Reset SHALL asynchronously force state IDLE, fetch_pc=0, imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0.
REQ-028 Reset mid-WAIT or mid-COND SHALL abandon the fetch/branch; a late imem_ready after reset is ignored until REQ.

Structure
REQ-029 Shared package SHALL hold state enum, opcode constants BR_UNCOND=7'b1100000, BR_COND=7'b1100001, condition-code constants, flag bit indices.
REQ-030 Condition evaluation SHALL be sub-module cond_eval (cond[3:0], flags[3:0] -> taken), combinational.

Verification
REQ-031 Reset, memory ready every cycle with non-branch words -> imem_addr 0,4,8,C; instr_pc matches each.
REQ-032 Fetch at 0x10 returns 0xC000FFF0 (B -16) -> next imem_addr 0x00.
REQ-033 Cond BEQ (cond 0001, imm 0x0020) at 0x40, flags_valid delayed 3 cycles, Z=1 -> imem_req=0 for 3 cycles, then addr 0x60; Z=0 -> 0x44.
REQ-034 stall=1 for 4 cycles with instr_valid=1 -> instr unchanged, imem_req=0, resumes at pc+4.
REQ-035 imem_ready held 0 for 5 cycles -> imem_addr stable; reset asserted in WAIT -> all outputs 0 same cycle, restart at 0.
REQ-036 All 16 cond codes swept over all 16 flag values -> taken matches REQ-021 table.
